// File: rtl/i2c_adc_target_pkg.sv
// Shared types and constants for the I2C ADC target: FSM state encoding,
// register indices and register reset values.
package i2c_adc_target_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWrMsb,
    StWrMsbAck,
    StWrLsb,
    StWrLsbAck,
    StRdByte,
    StRdAck,
    StWaitStop
  } state_t;

  localparam logic [1:0] RegConv     = 2'd0;
  localparam logic [1:0] RegConfig   = 2'd1;
  localparam logic [1:0] RegLoThresh = 2'd2;
  localparam logic [1:0] RegHiThresh = 2'd3;

  localparam logic [15:0] ConfigRst   = 16'h8583;
  localparam logic [15:0] LoThreshRst = 16'h8000;
  localparam logic [15:0] HiThreshRst = 16'h7FFF;
  localparam logic [1:0]  PtrRst      = RegConv;

endpackage

// File: rtl/i2c_adc_target_if.sv
// Register-side interface of the I2C ADC target: conversion input and
// the three host-writable registers with their write-commit strobe.
interface i2c_adc_target_if;

  logic [15:0] conv_data;
  logic        data_ready;
  logic [15:0] config_reg;
  logic [15:0] lo_thresh;
  logic [15:0] hi_thresh;
  logic        wr_strobe;
  logic [1:0]  wr_ptr;
  logic        busy;

  // Target side: the I2C block itself.
  modport slave (
    input  conv_data, data_ready,
    output config_reg, lo_thresh, hi_thresh, wr_strobe, wr_ptr, busy
  );

  // Host side: the ADC core that supplies data and consumes registers.
  modport master (
    output conv_data, data_ready,
    input  config_reg, lo_thresh, hi_thresh, wr_strobe, wr_ptr, busy
  );

endinterface

// File: rtl/i2c_bus_monitor.sv
// Synchronizes the raw scl/sda pins into the clk domain and detects scl
// edges plus START/STOP conditions on the synchronized signals.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl;

  // Synchronizer chains and one-cycle history; reset to idle bus (high) so
  // leaving reset never looks like a START or STOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_adc_target.sv
// I2C target exposing an ADC-style register file: conversion (read-only),
// config, low and high threshold. Pointer byte selects the register; data is
// 16 bits MSB first. Define I2C_ADC_TARGET_STRETCH_EN to hold scl low after a
// read-address ACK until data_ready is high.
module i2c_adc_target
  import i2c_adc_target_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  inout  wire              scl_pin,
  inout  wire              sda_pin,
  i2c_adc_target_if.slave  regs
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_monitor (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_pin),
    .sda_in    (sda_pin),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        phase_q, phase_d;
  logic        rw_q, rw_d;
  logic        byte_sel_q, byte_sel_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  msb_q, msb_d;
  logic [15:0] snap_q, snap_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [15:0] config_q, config_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;

  logic [7:0]  byte_in;
  logic [7:0]  next_tx;
  logic [15:0] rd_value;

`ifdef I2C_ADC_TARGET_STRETCH_EN
  logic scl_oe_q, scl_oe_d;
`else
  logic unused_data_ready;
  assign unused_data_ready = regs.data_ready;
`endif

  assign byte_in = {shift_q[6:0], sda};
  // After a master ACK the other half of the snapshot goes out next.
  assign next_tx = byte_sel_q ? snap_q[15:8] : snap_q[7:0];

  // Register selected by the pointer, as seen by a read.
  always_comb begin
    case (ptr_q)
      RegConv:     rd_value = regs.conv_data;
      RegConfig:   rd_value = config_q;
      RegLoThresh: rd_value = lo_q;
      default:     rd_value = hi_q;
    endcase
  end

  // Protocol FSM: next state, shift registers, register writes and drive.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    phase_d     = phase_q;
    rw_d        = rw_q;
    byte_sel_d  = byte_sel_q;
    ptr_d       = ptr_q;
    msb_d       = msb_q;
    snap_d      = snap_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    config_d    = config_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    wr_strobe_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
`ifdef I2C_ADC_TARGET_STRETCH_EN
    scl_oe_d    = scl_oe_q;
`endif

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
`ifdef I2C_ADC_TARGET_STRETCH_EN
      scl_oe_d  = 1'b0;
`endif
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
`ifdef I2C_ADC_TARGET_STRETCH_EN
      scl_oe_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: begin
          sda_oe_d = 1'b0;
        end

        StAddr, StPtr, StWrMsb, StWrLsb: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                StAddr: begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                    state_d = StAddrAck;
                    rw_d    = byte_in[0];
                    busy_d  = 1'b1;
                  end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                  end
                end
                StPtr: begin
                  ptr_d   = byte_in[1:0];
                  state_d = StPtrAck;
                end
                StWrMsb: begin
                  msb_d   = byte_in;
                  state_d = StWrMsbAck;
                end
                default: state_d = StWrLsbAck;
              endcase
            end
          end
        end

        // ACK slot: first falling edge starts driving low, second ends it.
        StAddrAck, StPtrAck, StWrMsbAck, StWrLsbAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = 1'b1;
`ifndef I2C_ADC_TARGET_STRETCH_EN
              if (state_q == StAddrAck && rw_q) snap_d = rd_value;
`endif
              if (state_q == StWrLsbAck && ptr_q != RegConv) begin
                wr_strobe_d = 1'b1;
                wr_ptr_d    = ptr_q;
                case (ptr_q)
                  RegConfig:   config_d = {msb_q, shift_q};
                  RegLoThresh: lo_d     = {msb_q, shift_q};
                  default:     hi_d     = {msb_q, shift_q};
                endcase
              end
            end else begin
              phase_d   = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              case (state_q)
                StAddrAck: begin
                  if (rw_q) begin
                    state_d    = StRdByte;
                    byte_sel_d = 1'b0;
`ifdef I2C_ADC_TARGET_STRETCH_EN
                    scl_oe_d   = 1'b1;
`else
                    tx_d       = snap_q[15:8];
                    sda_oe_d   = ~snap_q[15];
`endif
                  end else begin
                    state_d = StPtr;
                  end
                end
                StPtrAck:   state_d = StWrMsb;
                StWrMsbAck: state_d = StWrLsb;
                default:    state_d = StWrMsb;
              endcase
            end
          end
        end

        StRdByte: begin
`ifdef I2C_ADC_TARGET_STRETCH_EN
          // While stretching: load the first bit, then release scl a cycle
          // later so sda settles before the master sees scl rise.
          if (scl_oe_q) begin
            if (regs.data_ready) begin
              if (!phase_q) begin
                snap_d   = rd_value;
                tx_d     = rd_value[15:8];
                sda_oe_d = ~rd_value[15];
                phase_d  = 1'b1;
              end else begin
                scl_oe_d = 1'b0;
                phase_d  = 1'b0;
              end
            end
          end else
`endif
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              state_d   = StRdAck;
            end else begin
              tx_d      = tx_q << 1;
              sda_oe_d  = ~tx_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            if (sda) state_d = StWaitStop;
            else     phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_d    = 1'b0;
            byte_sel_d = ~byte_sel_q;
            tx_d       = next_tx;
            sda_oe_d   = ~next_tx[7];
            bit_cnt_d  = '0;
            state_d    = StRdByte;
          end
        end

        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and register file; reset forces idle bus and register defaults.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      phase_q     <= 1'b0;
      rw_q        <= 1'b0;
      byte_sel_q  <= 1'b0;
      ptr_q       <= PtrRst;
      msb_q       <= '0;
      snap_q      <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      config_q    <= ConfigRst;
      lo_q        <= LoThreshRst;
      hi_q        <= HiThreshRst;
      wr_strobe_q <= 1'b0;
      wr_ptr_q    <= '0;
`ifdef I2C_ADC_TARGET_STRETCH_EN
      scl_oe_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      phase_q     <= phase_d;
      rw_q        <= rw_d;
      byte_sel_q  <= byte_sel_d;
      ptr_q       <= ptr_d;
      msb_q       <= msb_d;
      snap_q      <= snap_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      config_q    <= config_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      wr_strobe_q <= wr_strobe_d;
      wr_ptr_q    <= wr_ptr_d;
`ifdef I2C_ADC_TARGET_STRETCH_EN
      scl_oe_q    <= scl_oe_d;
`endif
    end
  end

  assign sda_pin = sda_oe_q ? 1'b0 : 1'bz;
`ifdef I2C_ADC_TARGET_STRETCH_EN
  assign scl_pin = scl_oe_q ? 1'b0 : 1'bz;
`else
  assign scl_pin = 1'bz;
`endif

  assign regs.config_reg = config_q;
  assign regs.lo_thresh  = lo_q;
  assign regs.hi_thresh  = hi_q;
  assign regs.wr_strobe  = wr_strobe_q;
  assign regs.wr_ptr     = wr_ptr_q;
  assign regs.busy       = busy_q;

endmodule

// File: tb/tb_i2c_adc_target.sv
// Directed plus randomized bench for i2c_adc_target, acting as I2C master
// and checking against a register-array model of the target.
module tb_i2c_adc_target;
  import i2c_adc_target_pkg::*;

  localparam int Q = 100;  // quarter of an I2C bit period

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  scl_pin;
  wire  sda_pin;

  pullup (scl_pin);
  pullup (sda_pin);
  assign scl_pin = m_scl ? 1'bz : 1'b0;
  assign sda_pin = m_sda ? 1'bz : 1'b0;

  i2c_adc_target_if regs_if ();

  i2c_adc_target dut (
    .clk     (clk),
    .reset_n (reset_n),
    .scl_pin (scl_pin),
    .sda_pin (sda_pin),
    .regs    (regs_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  logic [1:0] last_wr_ptr = 2'd0;

  always @(negedge clk) begin
    if (regs_if.wr_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_wr_ptr = regs_if.wr_ptr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scl_high();
    int n;
    m_scl = 1'b1;
    n = 0;
    while (scl_pin !== 1'b1 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (scl_pin !== 1'b1) check("scl_release_timeout", 32'(scl_pin), 32'd1);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #(Q);
    scl_high(); #(2*Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; #(Q);
    scl_high(); #(Q);
    b = sda_pin; #(Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(~master_ack);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #(Q);
    scl_high(); #(Q);
    m_sda = 1'b0; #(Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #(Q);
    scl_high(); #(Q);
    m_sda = 1'b1; #(2*Q);
  endtask

  // Reference model: plain register array indexed by pointer.
  logic [15:0] model [4];
  logic [1:0]  mptr;
  logic        a, all_ack, bit_v;
  logic [7:0]  b0, b1, b2, b3;
  logic [15:0] conv, wdata, expv;
  logic [1:0]  p;
  logic [6:0]  bad;
  int          s0, exp_strobes, npairs;

  task automatic model_reset();
    model[0] = 16'h0;
    model[1] = 16'h8583;
    model[2] = 16'h8000;
    model[3] = 16'h7FFF;
    mptr = 2'd0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_config"}, 32'(regs_if.config_reg), 32'(model[1]));
    check({tag, "_lo"}, 32'(regs_if.lo_thresh), 32'(model[2]));
    check({tag, "_hi"}, 32'(regs_if.hi_thresh), 32'(model[3]));
  endtask

  initial begin
    regs_if.conv_data = 16'h0;
    regs_if.data_ready = 1'b1;
    model_reset();
    #(3*Q);
    check_regs("rst_in");
    @(negedge clk);
    reset_n = 1'b1;
    #(Q);
    check_regs("rst");
    check("rst_busy", 32'(regs_if.busy), 32'd0);
    check("rst_sda", 32'(sda_pin), 32'd1);
    check("rst_scl", 32'(scl_pin), 32'd1);
    check("rst_strobe", 32'(regs_if.wr_strobe), 32'd0);
    check("rst_wr_ptr", 32'(regs_if.wr_ptr), 32'd0);

    // Basic config write.
    s0 = strobe_cnt;
    all_ack = 1'b1;
    i2c_start();
    send_byte(8'h90, a); all_ack &= a;
    send_byte(8'h01, a); all_ack &= a;
    send_byte(8'h42, a); all_ack &= a;
    send_byte(8'h83, a); all_ack &= a;
    check("wr_busy", 32'(regs_if.busy), 32'd1);
    i2c_stop();
    model[1] = 16'h4283; mptr = 2'd1;
    check("wr_acks", 32'(all_ack), 32'd1);
    check("wr_strobe_cnt", 32'(strobe_cnt - s0), 32'd1);
    check("wr_ptr", 32'(last_wr_ptr), 32'd1);
    check_regs("wr");
    check("wr_busy_after_stop", 32'(regs_if.busy), 32'd0);

    // Wrong address: no ACK, nothing changes.
    i2c_start();
    send_byte(8'h92, a);
    check("badaddr_ack", 32'(a), 32'd0);
    check("badaddr_busy", 32'(regs_if.busy), 32'd0);
    i2c_stop();
    check_regs("badaddr");

    // Pointer 0 then repeated-start read of conversion register.
    s0 = strobe_cnt;
    regs_if.conv_data = 16'h1234;
    i2c_start();
    send_byte(8'h90, a); all_ack = a;
    send_byte(8'h00, a); all_ack &= a;
    i2c_start();
    send_byte(8'h91, a); all_ack &= a;
    regs_if.conv_data = 16'hBEEF;  // after snapshot
    recv_byte(b0, 1'b1);
    recv_byte(b1, 1'b0);
    mptr = 2'd0;
    check("rd_acks", 32'(all_ack), 32'd1);
    check("rd_msb", 32'(b0), 32'h12);
    check("rd_lsb", 32'(b1), 32'h34);
    check("rd_wait_stop", 32'(dut.state_q), 32'(StWaitStop));
    check("rd_sda_released", 32'(sda_pin), 32'd1);
    check("rd_busy", 32'(regs_if.busy), 32'd1);
    i2c_stop();
    check("rd_busy_after_stop", 32'(regs_if.busy), 32'd0);
    check("rd_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // STOP after MSB only discards the byte.
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h90, a);
    send_byte(8'h02, a);
    send_byte(8'hAB, a);
    i2c_stop();
    mptr = 2'd2;
    check("partial_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check_regs("partial");

    // Randomized write/readback transactions and stray addresses.
    for (int it = 0; it < 8; it++) begin
      p = 2'($urandom_range(0, 3));
      conv = 16'($urandom);
      regs_if.conv_data = conv;
      npairs = 1 + (it % 2);
      s0 = strobe_cnt;
      all_ack = 1'b1;
      i2c_start();
      send_byte(8'h90, a); all_ack &= a;
      send_byte({6'($urandom), p}, a); all_ack &= a;
      mptr = p;
      exp_strobes = 0;
      for (int k = 0; k < npairs; k++) begin
        wdata = 16'($urandom);
        send_byte(wdata[15:8], a); all_ack &= a;
        send_byte(wdata[7:0], a); all_ack &= a;
        if (mptr != 2'd0) begin
          model[mptr] = wdata;
          exp_strobes++;
        end
      end
      i2c_start();
      send_byte(8'h91, a); all_ack &= a;
      expv = (mptr == 2'd0) ? conv : model[mptr];
      regs_if.conv_data = 16'($urandom);
      recv_byte(b0, 1'b1);
      recv_byte(b1, 1'b1);
      recv_byte(b2, 1'b1);
      recv_byte(b3, 1'b0);
      i2c_stop();
      check("rnd_acks", 32'(all_ack), 32'd1);
      check("rnd_read0", 32'({b0, b1}), 32'(expv));
      check("rnd_read1", 32'({b2, b3}), 32'(expv));
      check("rnd_strobes", 32'(strobe_cnt - s0), 32'(exp_strobes));
      if (exp_strobes != 0) check("rnd_wr_ptr", 32'(last_wr_ptr), 32'(mptr));
      check_regs("rnd");

      bad = 7'($urandom_range(0, 127));
      if (bad == 7'h48) bad = 7'h49;
      i2c_start();
      send_byte({bad, 1'($urandom)}, a);
      check("rnd_badaddr_ack", 32'(a), 32'd0);
      check("rnd_badaddr_busy", 32'(regs_if.busy), 32'd0);
      i2c_stop();
    end

    // Pointer persists: read without a pointer write.
    conv = 16'($urandom);
    regs_if.conv_data = conv;
    expv = (mptr == 2'd0) ? conv : model[mptr];
    i2c_start();
    send_byte(8'h91, a);
    recv_byte(b0, 1'b1);
    recv_byte(b1, 1'b0);
    i2c_stop();
    check("persist_read", 32'({b0, b1}), 32'(expv));

    // Reset in the middle of a read byte.
    regs_if.conv_data = 16'h0012;
    i2c_start();
    send_byte(8'h90, a);
    send_byte(8'h00, a);
    i2c_start();
    send_byte(8'h91, a);
    for (int i = 0; i < 3; i++) recv_bit(bit_v);
    check("mid_read_driving", 32'(sda_pin), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_reset_sda", 32'(sda_pin), 32'd1);
    check("mid_reset_state", 32'(dut.state_q), 32'(StIdle));
    check("mid_reset_busy", 32'(regs_if.busy), 32'd0);
    model_reset();
    check_regs("mid_reset");
    m_scl = 1'b1;
    m_sda = 1'b1;
    #(Q);
    @(negedge clk);
    reset_n = 1'b1;
    #(Q);
    s0 = strobe_cnt;
    all_ack = 1'b1;
    i2c_start();
    send_byte(8'h90, a); all_ack &= a;
    send_byte(8'h03, a); all_ack &= a;
    send_byte(8'h12, a); all_ack &= a;
    send_byte(8'h34, a); all_ack &= a;
    i2c_stop();
    model[3] = 16'h1234;
    check("post_reset_acks", 32'(all_ack), 32'd1);
    check("post_reset_strobe", 32'(strobe_cnt - s0), 32'd1);
    check("post_reset_wr_ptr", 32'(last_wr_ptr), 32'd3);
    check_regs("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
